hazard_scoreboard: RTL

Parametrised successor to the fixed-opcode stall detector in the 5-stage pipelined MIPS CPU. It keeps a per-register countdown scoreboard of in-flight results and produces the ID-stage stall (covering both the old ID and EX stall cases) for configurable ALU and load latencies. It also exports a busy mask and a saturating stall-cycle performance counter. It sits beside the ID/EX pipeline register; a stall freezes PC and IF/ID and inserts a bubble into EX.

---
 rtl/hazard_scoreboard.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// -----------------------------------------------------------------------------
// Per-register countdown scoreboard that produces the ID-stage stall for a
// 5-stage MIPS-style pipeline with configurable ALU and load latencies.
// Each architectural register r (r != 0) has a 3-bit counter holding the
// number of cycles until its in-flight result can be forwarded to ID.
// A stall freezes PC and IF/ID and inserts a bubble into EX.
//
// Parameters:
//   REG_AW   register address width (2**REG_AW registers, r0 is hard zero)
//   ALU_LAT  cycles after issue until an RTYPE/ADDI result reaches ID (1..7)
//   LOAD_LAT cycles after issue until an LW result reaches ID (ALU_LAT..7)
//   CNT_W    width of the saturating stall-cycle counter
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   id_valid     ID holds a real instruction
//   id_kill      ID instruction squashed this cycle; suppresses issue/stall
//   id_op        ID opcode
//   id_rs/rt/rd  ID register fields
//   id_stall     combinational: hold ID and insert a bubble
//   issue        combinational: id_valid & ~id_kill & ~id_stall
//   busy         bit r set while register r has a pending result
//   stall_cycles saturating count of cycles with id_stall = 1
//   illegal_op   one-cycle pulse after an unsupported opcode issues
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int REG_AW   = 5,
    parameter int ALU_LAT  = 1,
    parameter int LOAD_LAT = 2,
    parameter int CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_valid,
    input  logic                   id_kill,
    input  logic [5:0]             id_op,
    input  logic [REG_AW-1:0]      id_rs,
    input  logic [REG_AW-1:0]      id_rt,
    input  logic [REG_AW-1:0]      id_rd,
    output logic                   id_stall,
    output logic                   issue,
    output logic [2**REG_AW-1:0]   busy,
    output logic [CNT_W-1:0]       stall_cycles,
    output logic                   illegal_op
);

    localparam int NREG = 2**REG_AW;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [2:0] ALU_LAT_C  = 3'(ALU_LAT);
    localparam logic [2:0] LOAD_LAT_C = 3'(LOAD_LAT);

    // ------------------------------------------------------------------
    // Instruction decode
    // ------------------------------------------------------------------
    logic              uses_rs;
    logic              uses_rt;
    logic              is_beq;
    logic              has_dest;
    logic [REG_AW-1:0] dest;
    logic [2:0]        dest_lat;
    logic              supported;
    logic              dest_we;

    always_comb begin
        uses_rs   = 1'b0;
        uses_rt   = 1'b0;
        is_beq    = 1'b0;
        has_dest  = 1'b0;
        dest      = id_rt;
        dest_lat  = ALU_LAT_C;
        supported = 1'b1;
        case (id_op)
            OP_RTYPE: begin
                uses_rs  = 1'b1;
                uses_rt  = 1'b1;
                has_dest = 1'b1;
                dest     = id_rd;
            end
            OP_ADDI: begin
                uses_rs  = 1'b1;
                has_dest = 1'b1;
            end
            OP_LW: begin
                uses_rs  = 1'b1;
                has_dest = 1'b1;
                dest_lat = LOAD_LAT_C;
            end
            OP_SW: begin
                uses_rs = 1'b1;
                uses_rt = 1'b1;
            end
            OP_BEQ: begin
                uses_rs = 1'b1;
                uses_rt = 1'b1;
                is_beq  = 1'b1;
            end
            OP_J: begin
            end
            default: begin
                supported = 1'b0;
            end
        endcase
    end

    // Register 0 is never recorded as a destination.
    assign dest_we = has_dest & (dest != '0);

    // ------------------------------------------------------------------
    // Counter array. cnt_view gives indexed read access to every counter,
    // with entry 0 tied to zero so r0 always reads as ready.
    // ------------------------------------------------------------------
    logic [NREG-1:0][2:0] cnt_view;

    assign cnt_view[0] = 3'd0;
    assign busy[0]     = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < NREG; gi++) begin : g_reg
            logic [2:0] cnt_q;
            logic [2:0] cnt_d;

            // A new issue to this register reloads the counter and takes
            // priority over the decrement; a busy register is simply
            // reloaded (WAW needs no stall).
            always_comb begin
                cnt_d = (cnt_q != 3'd0) ? (cnt_q - 3'd1) : 3'd0;
                if (issue && dest_we && (dest == REG_AW'(gi))) begin
                    cnt_d = dest_lat;
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_q <= 3'd0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign cnt_view[gi] = cnt_q;
            assign busy[gi]     = (cnt_q != 3'd0);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Operand readiness and stall
    // ------------------------------------------------------------------
    logic [2:0] rs_cnt;
    logic [2:0] rt_cnt;
    logic       rs_ready;
    logic       rt_ready;

    assign rs_cnt = cnt_view[id_rs];
    assign rt_cnt = cnt_view[id_rt];

    // BEQ resolves in ID and needs the value now (cnt == 0); every other
    // consumer reads in EX one cycle later, so cnt == 1 is early enough.
    assign rs_ready = (id_rs == '0) || (is_beq ? (rs_cnt == 3'd0) : (rs_cnt <= 3'd1));
    assign rt_ready = (id_rt == '0) || (is_beq ? (rt_cnt == 3'd0) : (rt_cnt <= 3'd1));

    assign id_stall = id_valid & ~id_kill &
                      ((uses_rs & ~rs_ready) | (uses_rt & ~rt_ready));
    assign issue    = id_valid & ~id_kill & ~id_stall;

    // ------------------------------------------------------------------
    // Stall-cycle counter (saturating) and illegal-opcode pulse
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] stall_cycles_q;
    logic [CNT_W-1:0] stall_cycles_d;
    logic             illegal_op_q;
    logic             illegal_op_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (id_stall && (stall_cycles_q != {CNT_W{1'b1}})) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
        illegal_op_d = issue & ~supported;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles_q <= '0;
            illegal_op_q   <= 1'b0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            illegal_op_q   <= illegal_op_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign illegal_op   = illegal_op_q;

endmodule
